mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the EX stage.
- Consumes the EX outputs (ALU result/effective address, rt store data, zero, branch target) plus the MEM/WB control bits carried from ID.
- Contains the word-addressed data memory with configurable access latency and a busy FSM that stalls upstream. Resolves branches (pcsrc).
- Registers the MEM/WB pipeline outputs.

Parameters:
- DEPTH_WORDS, 256, data memory depth in 32-bit words; must be a power of 2.
- MEM_LATENCY, 2, cycles from acceptance to result for loads and stores; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- valid_in  in  1  EX output holds a valid instruction
- resultOut  in  32  ALU result / effective address
- rt  in  32  store data
- memRead  in  1  load
- memWrite  in  1  store
- regWrite  in  1  instruction writes the register file
- memToReg  in  1  writeback selects memory data (1) or ALU result (0)
- writeReg  in  5  destination register
- branch  in  1  instruction is a branch
- zero  in  1  ALU zero flag
- pcout  in  32  branch target from EX
- stall  out  1  upstream must hold its inputs
- pcsrc  out  1  take branch
- branch_target  out  32  registered pcout
- wb_valid  out  1  MEM/WB contents valid (one-cycle pulse per instruction)
- wb_regWrite  out  1
- wb_writeReg  out  5
- wb_data  out  32  final writeback value (load data or ALU result)
- misaligned  out  1  one-cycle pulse, alignment fault on the completing instruction

Behaviour:
- Reset (reset==0 at a rising edge): FSM goes to IDLE, counter cleared. All outputs become 0: stall, pcsrc, branch_target, wb_*, misaligned. Memory contents are not cleared by reset; they are zero-initialised at time 0.
- Reset mid-operation: the in-flight instruction is aborted and any pending store is not performed.
- FSM states:
  - IDLE: stall=0.
  - BUSY: stall=1, combinational from state.
- Acceptance: valid_in=1 and stall=0 at a rising edge.
- Inputs are ignored while stall=1. Upstream holds them, but the stage latches its own copy at acceptance.
- Non-memory instruction (memRead=0, memWrite=0):
  - Outputs are registered one edge after acceptance.
  - wb_valid=1, wb_data=resultOut, wb_regWrite=regWrite, wb_writeReg=writeReg.
  - pcsrc=branch&zero; branch_target=pcout.
  - Stays in IDLE.
- Memory instruction with MEM_LATENCY=1: completes at the next edge with no stall.
- Memory instruction with MEM_LATENCY>1:
  - Go to BUSY; counter loads MEM_LATENCY-1 and decrements each edge.
  - At count==1 the next edge completes the access and returns to IDLE.
  - stall is high for exactly MEM_LATENCY-1 cycles.
  - wb_valid pulses in the cycle following the MEM_LATENCY-th edge after acceptance.
- Completion:
  - A store writes rt to mem[resultOut[log2(DEPTH_WORDS)+1:2]] at the completion edge.
  - A load sets wb_data to that word when memToReg=1, otherwise to resultOut.
  - For a load, wb_data reflects any store completed earlier.
- Address bits above the index are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Misaligned access (resultOut[1:0]!=0 on a load or store):
  - Memory is not written; wb_regWrite forced to 0; misaligned=1.
  - Same latency and stall as an aligned access.
- memRead and memWrite both set: treated as a store; wb_regWrite forced to 0.
- Pulsed outputs: pcsrc, wb_valid and misaligned are high for one cycle per completion and 0 otherwise. wb_data, wb_writeReg and branch_target hold their last values.
- Back-to-back: a new instruction may be accepted in the same cycle the previous one's outputs appear (state IDLE).

Optional Feature:
- Macro: MEM_BYTE_ACCESS_EN.
- When defined:
  - Adds ports memSize in 2 (00 byte, 01 half, 10 word, 11 treated as word) and memSigned in 1.
  - Loads extract the byte or half at resultOut[1:0] (little-endian), then sign- or zero-extend per memSigned.
  - Stores update only the selected bytes.
  - Alignment rules: byte always aligned; half requires resultOut[0]=0; word requires [1:0]=0.
- When undefined: ports absent; word-only access as above.

Test Plan:
- MEM_LATENCY=2:
  - Store rt=0xDEADBEEF to resultOut=0x10; stall=1 for 1 cycle.
  - Then load from 0x10 with memToReg=1, writeReg=8 -> wb_data=0xDEADBEEF, wb_writeReg=8, wb_valid one pulse 2 cycles after acceptance.
- Non-memory op: resultOut=10, regWrite=1, writeReg=3 -> next cycle wb_valid=1, wb_data=10, stall never asserted.
- Branch: branch=1, zero=1, pcout=0x40 -> pcsrc=1 for one cycle, branch_target=0x40; with zero=0 -> pcsrc=0.
- Misaligned store to 0x12 with rt=0x1234 -> misaligned=1, wb_regWrite=0; a later load of 0x10 returns its prior value.
- Reset mid-operation (MEM_LATENCY=4): drive reset=0 during BUSY of a store to 0x20 -> stall=0 and all outputs 0 the next cycle; a later load of 0x20 returns 0.
- Address wrap: DEPTH_WORDS=256, store 0x55 to 0x400 -> a load from 0x0 returns 0x55.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS MEM stage: word-addressed data memory with fixed access latency, busy/stall FSM,
// branch resolution and MEM/WB output registers. Optional sub-word access under MEM_BYTE_ACCESS_EN.
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MEM_BYTE_ACCESS_EN
  input  logic [1:0]  memSize,
  input  logic        memSigned,
`endif
  input  logic        valid_in,
  input  logic [31:0] resultOut,
  input  logic [31:0] rt,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic [4:0]  writeReg,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] pcout,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        wb_valid,
  output logic        wb_regWrite,
  output logic [4:0]  wb_writeReg,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic        rd_q, wr_q, rw_q, m2r_q, br_q, zero_q;
  logic [4:0]  wreg_q;
  logic        pcsrc_q, wb_valid_q, wb_rw_q, mis_q;
  logic [4:0]  wb_wreg_q;
  logic [31:0] wb_data_q, bt_q;
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic        busy, accept, complete;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic        op_rd, op_wr, op_rw, op_m2r, op_br, op_zero, is_st, is_ld, mis;
  logic [4:0]  op_wreg;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, ld_val, wd_rep;
  logic [3:0]  be;
  logic        bad_align;

  assign busy  = (state_q == BUSY);
  assign stall = busy;
  assign accept = valid_in & ~busy;

  // While BUSY the stage works from its own copy; upstream may change its outputs freely.
  assign op_addr  = busy ? addr_q  : resultOut;
  assign op_wdata = busy ? wdata_q : rt;
  assign op_pc    = busy ? pc_q    : pcout;
  assign op_rd    = busy ? rd_q    : memRead;
  assign op_wr    = busy ? wr_q    : memWrite;
  assign op_rw    = busy ? rw_q    : regWrite;
  assign op_m2r   = busy ? m2r_q   : memToReg;
  assign op_br    = busy ? br_q    : branch;
  assign op_zero  = busy ? zero_q  : zero;
  assign op_wreg  = busy ? wreg_q  : writeReg;

  assign is_st   = op_wr;
  assign is_ld   = op_rd & ~op_wr;
  assign idx     = op_addr[AW+1:2];
  assign rd_word = mem_q[idx];
  assign mis     = (is_st | is_ld) & bad_align;

  assign complete = busy ? (cnt_q == 4'd1)
                         : (accept & (~(memRead | memWrite) | (MEM_LATENCY == 1)));

`ifdef MEM_BYTE_ACCESS_EN
  logic [1:0]  size_q, op_size;
  logic        sgn_q, op_sgn;
  logic [31:0] shifted;

  assign op_size = busy ? size_q : memSize;
  assign op_sgn  = busy ? sgn_q  : memSigned;
  assign shifted = rd_word >> {op_addr[1:0], 3'b000};

  always_comb begin
    ld_val    = rd_word;
    wd_rep    = op_wdata;
    be        = 4'hF;
    bad_align = (op_addr[1:0] != 2'b00);
    case (op_size)
      2'b00: begin
        ld_val    = {{24{op_sgn & shifted[7]}}, shifted[7:0]};
        wd_rep    = {4{op_wdata[7:0]}};
        be        = 4'b0001 << op_addr[1:0];
        bad_align = 1'b0;
      end
      2'b01: begin
        ld_val    = {{16{op_sgn & shifted[15]}}, shifted[15:0]};
        wd_rep    = {2{op_wdata[15:0]}};
        be        = 4'b0011 << {op_addr[1], 1'b0};
        bad_align = op_addr[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      size_q <= memSize;
      sgn_q  <= memSigned;
    end
  end
`else
  assign ld_val    = rd_word;
  assign wd_rep    = op_wdata;
  assign be        = 4'hF;
  assign bad_align = (op_addr[1:0] != 2'b00);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = IDLE;
    end else if (accept && (memRead || memWrite) && (MEM_LATENCY > 1)) begin
      state_d = BUSY;
      cnt_d   = 4'(MEM_LATENCY - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pcsrc_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      mis_q      <= 1'b0;
      wb_wreg_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      bt_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= complete;
      pcsrc_q    <= complete & op_br & op_zero;
      mis_q      <= complete & mis;
      if (complete) begin
        wb_rw_q   <= op_rw & ~op_wr & ~mis;
        wb_wreg_q <= op_wreg;
        wb_data_q <= (is_ld & op_m2r & ~mis) ? ld_val : op_addr;
        bt_q      <= op_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= resultOut;
      wdata_q <= rt;
      pc_q    <= pcout;
      rd_q    <= memRead;
      wr_q    <= memWrite;
      rw_q    <= regWrite;
      m2r_q   <= memToReg;
      br_q    <= branch;
      zero_q  <= zero;
      wreg_q  <= writeReg;
    end
  end

  // Store gated by reset so an aborted access never lands in memory.
  always_ff @(posedge clk) begin
    if (reset && complete && is_st && !mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wd_rep[8*b +: 8];
      end
    end
  end

  assign pcsrc         = pcsrc_q;
  assign branch_target = bt_q;
  assign wb_valid      = wb_valid_q;
  assign wb_regWrite   = wb_rw_q;
  assign wb_writeReg   = wb_wreg_q;
  assign wb_data       = wb_data_q;
  assign misaligned    = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed plan steps plus randomized ops against a word-array model.
module tb_mem_stage;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset4, valid_in, valid4;
  logic [31:0] resultOut, rt, pcout;
  logic        memRead, memWrite, regWrite, memToReg, branch, zero;
  logic [4:0]  writeReg;
  logic        stall, pcsrc, wb_valid, wb_regWrite, misaligned;
  logic [31:0] branch_target, wb_data;
  logic [4:0]  wb_writeReg;
  logic        stall4, pcsrc4, wbv4, wbrw4, mis4;
  logic [31:0] bt4, wbd4;
  logic [4:0]  wbwr4;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [256];

  mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
`ifdef MEM_BYTE_ACCESS_EN
    .memSize(2'b10), .memSigned(1'b0),
`endif
    .valid_in(valid_in), .resultOut(resultOut), .rt(rt), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg), .writeReg(writeReg),
    .branch(branch), .zero(zero), .pcout(pcout), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_writeReg(wb_writeReg), .wb_data(wb_data), .misaligned(misaligned));

  mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset4),
`ifdef MEM_BYTE_ACCESS_EN
    .memSize(2'b10), .memSigned(1'b0),
`endif
    .valid_in(valid4), .resultOut(resultOut), .rt(rt), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg), .writeReg(writeReg),
    .branch(branch), .zero(zero), .pcout(pcout), .stall(stall4), .pcsrc(pcsrc4),
    .branch_target(bt4), .wb_valid(wbv4), .wb_regWrite(wbrw4),
    .wb_writeReg(wbwr4), .wb_data(wbd4), .misaligned(mis4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input bit rw, input bit m2r,
                       input logic [4:0] wreg, input logic [31:0] addr, input logic [31:0] wd,
                       input bit br, input bit zr, input logic [31:0] pc);
    memRead = rd; memWrite = wr; regWrite = rw; memToReg = m2r; writeReg = wreg;
    resultOut = addr; rt = wd; branch = br; zero = zr; pcout = pc;
  endtask

  // One instruction on the latency-LAT instance; expectations come from model_mem.
  task automatic do_op(input string tag, input bit rd, input bit wr, input bit rw, input bit m2r,
                       input logic [4:0] wreg, input logic [31:0] addr, input logic [31:0] wd,
                       input bit br, input bit zr, input logic [31:0] pc);
    bit is_st, is_ld, mis, exp_rw;
    int idx, exp_lat, stalls, edges;
    logic [31:0] exp_data;
    is_st = wr;
    is_ld = rd && !wr;
    mis = (is_st || is_ld) && (addr[1:0] != 2'b00);
    idx = int'(addr[9:2]);
    exp_data = (is_ld && m2r) ? model_mem[idx] : addr;
    exp_rw = rw && !wr && !mis;
    exp_lat = (rd || wr) ? LAT : 1;
    drive(rd, wr, rw, m2r, wreg, addr, wd, br, zr, pc);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, 5'($urandom), $urandom, $urandom,
          $urandom, $urandom, $urandom);
    edges = 1;
    stalls = 0;
    while (!wb_valid && edges < 20) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat - 1);
    chk({tag, "_stall_end"}, stall, 0);
    chk({tag, "_wb_writeReg"}, wb_writeReg, wreg);
    chk({tag, "_wb_regWrite"}, wb_regWrite, exp_rw);
    chk({tag, "_misaligned"}, misaligned, mis);
    chk({tag, "_pcsrc"}, pcsrc, br && zr);
    chk({tag, "_branch_target"}, branch_target, pc);
    if (!mis) chk({tag, "_wb_data"}, wb_data, exp_data);
    if (is_st && !mis) model_mem[idx] = wd;
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, wb_valid, 0);
    chk({tag, "_pcsrc_pulse"}, pcsrc, 0);
    chk({tag, "_mis_pulse"}, misaligned, 0);
    chk({tag, "_data_hold"}, wb_data, (mis ? wb_data : exp_data));
  endtask

  initial begin
    int edges;
    bit rd, wr;
    int kind;
    logic [31:0] addr;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    reset = 1'b0; reset4 = 1'b0; valid_in = 1'b0; valid4 = 1'b0;
    drive(1, 1, 1, 1, 5'd31, 32'hFFFF_FFFF, 32'h1, 1, 1, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_pcsrc", pcsrc, 0);
    chk("rst_branch_target", branch_target, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regWrite", wb_regWrite, 0);
    chk("rst_wb_writeReg", wb_writeReg, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misaligned", misaligned, 0);
    reset = 1'b1; reset4 = 1'b1;
    @(posedge clk); #1;

    do_op("store_10", 0, 1, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
    do_op("load_10", 1, 0, 1, 1, 5'd8, 32'h10, 32'h0, 0, 0, 32'h4);
    do_op("alu_op", 0, 0, 1, 0, 5'd3, 32'd10, 32'h0, 0, 0, 32'h8);
    do_op("branch_taken", 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 1, 32'h40);
    do_op("branch_not", 0, 0, 0, 0, 5'd0, 32'h4, 32'h0, 1, 0, 32'h80);
    do_op("mis_store", 0, 1, 1, 0, 5'd2, 32'h12, 32'h1234, 0, 0, 32'h0);
    do_op("load_after_mis", 1, 0, 1, 1, 5'd9, 32'h10, 32'h0, 0, 0, 32'h0);
    do_op("mis_load", 1, 0, 1, 1, 5'd9, 32'h11, 32'h0, 0, 0, 32'h0);
    do_op("wrap_store", 0, 1, 0, 0, 5'd0, 32'h400, 32'h55, 0, 0, 32'h0);
    do_op("wrap_load", 1, 0, 1, 1, 5'd4, 32'h0, 32'h0, 0, 0, 32'h0);
    do_op("rd_wr_both", 1, 1, 1, 1, 5'd6, 32'h24, 32'hA5A5_0F0F, 0, 0, 32'h0);
    do_op("load_24", 1, 0, 1, 1, 5'd7, 32'h24, 32'h0, 0, 0, 32'h0);
    do_op("load_no_m2r", 1, 0, 1, 0, 5'd7, 32'h24, 32'h0, 0, 0, 32'h0);

    // Back-to-back: second op accepted in the cycle the first one's outputs appear.
    drive(0, 0, 1, 0, 5'd11, 32'h111, 32'h0, 0, 0, 32'h0);
    valid_in = 1'b1;
    @(posedge clk); #1;
    chk("b2b_first_valid", wb_valid, 1);
    chk("b2b_first_data", wb_data, 32'h111);
    drive(0, 0, 1, 0, 5'd12, 32'h222, 32'h0, 0, 0, 32'h0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("b2b_second_valid", wb_valid, 1);
    chk("b2b_second_data", wb_data, 32'h222);
    chk("b2b_second_reg", wb_writeReg, 12);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      addr = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 10);
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      do_op($sformatf("rand%0d", n), rd, wr, $urandom, $urandom, 5'($urandom), addr,
            $urandom, $urandom, $urandom, $urandom);
    end

    // Reset during BUSY on the latency-4 instance aborts the pending store.
    drive(0, 1, 0, 0, 5'd0, 32'h20, 32'hCAFE_F00D, 0, 0, 32'h0);
    valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
    chk("l4_busy", stall4, 1);
    @(posedge clk); #1;
    reset4 = 1'b0;
    @(posedge clk); #1;
    reset4 = 1'b1;
    chk("l4_rst_stall", stall4, 0);
    chk("l4_rst_wb_valid", wbv4, 0);
    chk("l4_rst_wb_data", wbd4, 0);
    chk("l4_rst_bt", bt4, 0);
    chk("l4_rst_misaligned", mis4, 0);
    drive(1, 0, 1, 1, 5'd5, 32'h20, 32'h0, 0, 0, 32'h0);
    valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
    edges = 1;
    while (!wbv4 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("l4_load_valid", wbv4, 1);
    chk("l4_load_latency", edges, 4);
    chk("l4_load_data", wbd4, 0);
    chk("l4_load_reg", wbwr4, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
